// File: rtl/qformat_pkg.sv
// Shared definitions for the signed-magnitude fixed-point arithmetic blocks
// (multiplier and adder): default format, control states and field helpers.
package qformat_pkg;

  localparam int DEF_N = 32;
  localparam int DEF_Q = 15;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // Saturated magnitude for the default word width.
  localparam logic [DEF_N-2:0] SAT_MAG = '1;

  // Helpers take the word zero-extended to 64 bits plus its real width,
  // so one definition serves every N up to 64.
  function automatic logic sm_sign(input logic [63:0] w, input int unsigned n);
    return w[n-1];
  endfunction

  function automatic logic [63:0] sm_mag(input logic [63:0] w, input int unsigned n);
    logic [63:0] mask;
    mask = (64'd1 << (n - 1)) - 64'd1;
    return w & mask;
  endfunction

endpackage

// File: rtl/qmult_seq.sv
// Multi-cycle signed-magnitude fixed-point multiplier: one multiplier bit per
// clock through a shift-add datapath, truncating and saturating the product.
module qmult_seq
  import qformat_pkg::*;
#(
  parameter int N = DEF_N,
  parameter int Q = DEF_Q
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_start,
  input  logic [N-1:0] i_multiplicand,
  input  logic [N-1:0] i_multiplier,
  output logic         o_ready,
  output logic         o_busy,
  output logic         o_complete,
  output logic [N-1:0] o_result,
  output logic         o_overflow
);

  localparam int M     = N - 1;      // magnitude width
  localparam int ACC_W = 2 * M;      // full product width
  localparam int CW    = $clog2(N);

  state_t state, state_nx;

  logic [ACC_W-1:0] acc, acc_nx, a_sh;
  logic [M-1:0]     mag_b;
  logic [CW-1:0]    cnt;
  logic             sign;

  logic             load, step, last;
  logic [M-1:0]     cand_mag, fin_mag;
  logic             ovf;

  assign last = (cnt == CW'(N - 2));

  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // the pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // NOTE: every output of this block is given a default first, so no path
  // leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_nx   = state;
    load       = 1'b0;
    step       = 1'b0;
    o_ready    = 1'b0;
    o_busy     = 1'b0;
    o_complete = 1'b0;
    unique case (state)
      IDLE: begin
        o_ready = 1'b1;
        if (i_start) begin
          load     = 1'b1;
          state_nx = BUSY;
        end
      end
      BUSY: begin
        o_busy = 1'b1;
        step   = 1'b1;
        if (last) state_nx = DONE;
      end
      DONE: begin
        o_complete = 1'b1;
        state_nx   = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Partial-product update for the current multiplier bit.
  always_comb begin
    acc_nx = acc;
    if (mag_b[0]) acc_nx = acc + a_sh;
  end

  // Fixed-point realignment of the finished product: drop Q fraction bits,
  // saturate if anything remains above the magnitude field.
  assign cand_mag = acc_nx[M-1+Q:Q];
  assign ovf      = |acc_nx[ACC_W-1:M+Q];
  assign fin_mag  = ovf ? {M{1'b1}} : cand_mag;

  always_ff @(posedge clk) begin
    if (rst) begin
      acc        <= '0;
      a_sh       <= '0;
      mag_b      <= '0;
      cnt        <= '0;
      sign       <= 1'b0;
      o_result   <= '0;
      o_overflow <= 1'b0;
    end else if (load) begin
      acc   <= '0;
      cnt   <= '0;
      a_sh  <= ACC_W'(M'(sm_mag(64'(i_multiplicand), N)));
      mag_b <= M'(sm_mag(64'(i_multiplier), N));
      sign  <= sm_sign(64'(i_multiplicand), N) ^ sm_sign(64'(i_multiplier), N);
    end else if (step) begin
      acc   <= acc_nx;
      a_sh  <= a_sh << 1;
      mag_b <= mag_b >> 1;
      cnt   <= cnt + CW'(1);
      if (last) begin
        // A zero magnitude is always emitted as +0.
        o_result   <= {sign & (|fin_mag), fin_mag};
        o_overflow <= ovf;
      end
    end
  end

endmodule

// File: tb/tb_qmult_seq.sv
// Self-checking bench for qmult_seq: directed cases plus randomized operands
// against an arithmetic reference of the signed-magnitude product.
module tb_qmult_seq;

  localparam int N   = 32;
  localparam int Q   = 15;
  localparam int LAT = N - 1;
  localparam int MAX_WAIT = 60;

  logic         clk;
  logic         rst;
  logic         i_start;
  logic [N-1:0] i_multiplicand;
  logic [N-1:0] i_multiplier;
  logic         o_ready;
  logic         o_busy;
  logic         o_complete;
  logic [N-1:0] o_result;
  logic         o_overflow;

  int errors = 0;
  int checks = 0;

  qmult_seq #(.N(N), .Q(Q)) dut (
    .clk            (clk),
    .rst            (rst),
    .i_start        (i_start),
    .i_multiplicand (i_multiplicand),
    .i_multiplier   (i_multiplier),
    .o_ready        (o_ready),
    .o_busy         (o_busy),
    .o_complete     (o_complete),
    .o_result       (o_result),
    .o_overflow     (o_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: real product of the magnitudes, scaled back by 2^Q.
  function automatic logic [N:0] model(input logic [N-1:0] a, input logic [N-1:0] b);
    longint unsigned ma, mb, p, mag;
    logic ov, s;
    logic [N-2:0] m;
    ma  = longint'(a[N-2:0]);
    mb  = longint'(b[N-2:0]);
    p   = ma * mb;
    mag = p / (64'd1 << Q);
    ov  = (mag >= (64'd1 << (N - 1)));
    m   = ov ? {(N-1){1'b1}} : mag[N-2:0];
    s   = (a[N-1] ^ b[N-1]) && (m != 0);
    return {ov, s, m};
  endfunction

  // Waits (bounded) for o_ready, then presents a start for one edge.
  // Leaves the bench at the negedge following the acceptance edge.
  task automatic start_op(input logic [N-1:0] a, input logic [N-1:0] b);
    int n;
    n = 0;
    while (o_ready !== 1'b1 && n < MAX_WAIT) begin
      @(posedge clk); @(negedge clk); n++;
    end
    checks++;
    if (o_ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_wait: o_ready=%b required 1", o_ready);
    end
    i_start = 1'b1; i_multiplicand = a; i_multiplier = b;
    @(posedge clk); @(negedge clk);
    i_start = 1'b0;
    // Scramble operands after acceptance; the result must not depend on them.
    i_multiplicand = $urandom; i_multiplier = $urandom;
  endtask

  // Counts edges to o_complete, then checks latency, result, overflow and
  // the return to IDLE with the result held.
  task automatic finish_op(input string name, input logic [N-1:0] a, input logic [N-1:0] b);
    logic [N:0] exp;
    int lat;
    exp = model(a, b);
    lat = 0;
    while (o_complete !== 1'b1 && lat < MAX_WAIT) begin
      @(posedge clk); @(negedge clk); lat++;
    end
    checks++;
    if (lat != LAT) begin
      errors++;
      $display("FAIL %s latency: got %0d edges required %0d", name, lat, LAT);
    end
    checks++;
    if (o_result !== exp[N-1:0] || o_overflow !== exp[N]) begin
      errors++;
      $display("FAIL %s result: got %h ovf=%b required %h ovf=%b",
               name, o_result, o_overflow, exp[N-1:0], exp[N]);
    end
    @(posedge clk); @(negedge clk);
    checks++;
    if (o_complete !== 1'b0 || o_ready !== 1'b1 || o_result !== exp[N-1:0] ||
        o_overflow !== exp[N]) begin
      errors++;
      $display("FAIL %s hold: complete=%b ready=%b result=%h ovf=%b required 0 1 %h %b",
               name, o_complete, o_ready, o_result, o_overflow, exp[N-1:0], exp[N]);
    end
  endtask

  task automatic run_op(input string name, input logic [N-1:0] a, input logic [N-1:0] b);
    start_op(a, b);
    finish_op(name, a, b);
  endtask

  task automatic test_reset();
    rst = 1'b1; i_start = 1'b0; i_multiplicand = '0; i_multiplier = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (o_ready !== 1'b1 || o_busy !== 1'b0 || o_complete !== 1'b0 ||
        o_result !== '0 || o_overflow !== 1'b0) begin
      errors++;
      $display("FAIL reset: ready=%b busy=%b complete=%b result=%h ovf=%b required 1 0 0 0 0",
               o_ready, o_busy, o_complete, o_result, o_overflow);
    end
  endtask

  task automatic test_directed();
    run_op("1.5x2.0",   32'h0000C000, 32'h00010000);
    run_op("-1.0x2.5",  32'h80008000, 32'h00014000);
    run_op("-1.0x-1.0", 32'h80008000, 32'h80008000);
    run_op("neg_zero",  32'h80000000, 32'h00018000);
    run_op("truncate",  32'h00000001, 32'h00000001);
    run_op("trunc_neg", 32'h80000001, 32'h00004000);
  endtask

  task automatic test_overflow();
    run_op("ovf_pos",  32'h40000000, 32'h00020000);
    checks++;
    if (o_result !== 32'h7FFFFFFF || o_overflow !== 1'b1) begin
      errors++;
      $display("FAIL ovf_pos_const: got %h %b required 7fffffff 1", o_result, o_overflow);
    end
    run_op("ovf_neg",  32'h40000000, 32'h80020000);
    run_op("ovf_edge", 32'h7FFFFFFF, 32'h00008001);
    run_op("ovf_clear", 32'h00008000, 32'h00008000);
  endtask

  task automatic test_handshake();
    logic [N-1:0] a, b;
    logic [N:0]   exp;
    int cyc;
    int bad_ready;
    a = 32'h00024000; b = 32'h80011000;
    exp = model(a, b);
    start_op(a, b);
    bad_ready = 0;
    cyc = 0;
    while (o_complete !== 1'b1 && cyc < MAX_WAIT) begin
      if (o_ready !== 1'b0) bad_ready++;
      if (cyc == 5 || cyc == 20) begin
        i_start = 1'b1; i_multiplicand = 32'h00010000; i_multiplier = 32'h00010000;
      end
      @(posedge clk); @(negedge clk);
      i_start = 1'b0;
      cyc++;
    end
    checks++;
    if (bad_ready != 0 || cyc != LAT) begin
      errors++;
      $display("FAIL hs_busy: ready_high=%0d cycles=%0d required 0 and %0d", bad_ready, cyc, LAT);
    end
    checks++;
    if (o_result !== exp[N-1:0] || o_overflow !== exp[N]) begin
      errors++;
      $display("FAIL hs_result: got %h required %h", o_result, exp[N-1:0]);
    end
    // Start presented during DONE is ignored; state returns to IDLE.
    i_start = 1'b1; i_multiplicand = 32'h00018000; i_multiplier = 32'h00018000;
    @(posedge clk); @(negedge clk);
    checks++;
    if (o_ready !== 1'b1 || o_busy !== 1'b0) begin
      errors++;
      $display("FAIL hs_done_start: ready=%b busy=%b required 1 0", o_ready, o_busy);
    end
    // Start held into the IDLE cycle is accepted.
    @(posedge clk); @(negedge clk);
    i_start = 1'b0;
    checks++;
    if (o_busy !== 1'b1) begin
      errors++;
      $display("FAIL hs_idle_start: busy=%b required 1", o_busy);
    end
    finish_op("hs_followup", 32'h00018000, 32'h00018000);
  endtask

  task automatic test_mid_reset();
    start_op(32'h00030000, 32'h00030000);
    repeat (9) begin @(posedge clk); @(negedge clk); end
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    checks++;
    if (o_ready !== 1'b1 || o_busy !== 1'b0 || o_result !== '0 ||
        o_overflow !== 1'b0 || o_complete !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: ready=%b busy=%b result=%h ovf=%b required 1 0 0 0",
               o_ready, o_busy, o_result, o_overflow);
    end
    run_op("after_reset", 32'h00014000, 32'h80006000);
  endtask

  task automatic test_back_to_back();
    logic [N-1:0] a2, b2;
    a2 = 32'h00020000; b2 = 32'h0000A000;
    i_start = 1'b1; i_multiplicand = 32'h00011000; i_multiplier = 32'h00013000;
    @(posedge clk); @(negedge clk);
    i_multiplicand = a2; i_multiplier = b2;
    finish_op("b2b_first", 32'h00011000, 32'h00013000);
    // finish_op ends in IDLE with start still high: next edge accepts.
    @(posedge clk); @(negedge clk);
    i_start = 1'b0;
    checks++;
    if (o_busy !== 1'b1) begin
      errors++;
      $display("FAIL b2b_accept: busy=%b required 1", o_busy);
    end
    i_multiplicand = $urandom; i_multiplier = $urandom;
    finish_op("b2b_second", a2, b2);
  endtask

  task automatic test_random();
    logic [N-1:0] a, b;
    for (int i = 0; i < 24; i++) begin
      a = $urandom; b = $urandom;
      // Shrink magnitudes on most iterations so in-range products dominate.
      if (i % 4 != 0) begin
        a[N-2:0] = a[N-2:0] >> $urandom_range(8, 20);
        b[N-2:0] = b[N-2:0] >> $urandom_range(8, 20);
      end
      run_op($sformatf("rand%0d", i), a, b);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_overflow();
    test_handshake();
    test_mid_reset();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/qmult_seq.md
Name: qmult_seq

Overview:
- Multi-cycle signed-magnitude fixed-point multiplier. Operands are N bits: bit N-1 is the sign, bits N-2:0 are the magnitude, and the low Q bits are fractional.
- Sits directly upstream of the sign-magnitude adder. Its o_result feeds the adder's operand input, and the two together form the multiply-accumulate path.
- Uses a shift-add datapath that processes one multiplier bit per clock, trading latency for area.

Parameters:
- N, 32, total word width including the sign bit.
- Q, 15, number of fractional bits. Constraint: Q < N-1.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- i_start  input  1  request to begin a multiply; sampled only in IDLE.
- i_multiplicand  input  N  signed-magnitude operand A; sampled on the edge that accepts i_start.
- i_multiplier  input  N  signed-magnitude operand B; sampled on the same edge.
- o_ready  output  1  high in IDLE only.
- o_busy  output  1  high in BUSY only.
- o_complete  output  1  one-cycle pulse when o_result is updated.
- o_result  output  N  signed-magnitude product; held until the next completion.
- o_overflow  output  1  product magnitude exceeded N-1 bits; held with o_result.

Behaviour:
- Reset: state=IDLE, o_result=0, o_overflow=0, o_complete=0, o_busy=0, o_ready=1. Reset mid-operation aborts the multiply; the partial product is discarded.
- IDLE -> BUSY: on an edge with i_start=1.
  - Latch magA and magB (N-1 bits each) and sign = A[N-1]^B[N-1].
  - Clear the 2(N-1)-bit accumulator and the bit counter.
- BUSY: each edge processes one multiplier bit (LSB first).
  - If the current bit is 1, add magA, shifted left by the bit count, into the accumulator.
  - Increment the counter.
  - After exactly N-1 iterations, go to DONE.
- BUSY -> DONE register update, on that final edge:
  - Candidate magnitude = acc[N-2+Q : Q]. Truncate toward zero; no rounding.
  - If any of acc[2N-3 : N-1+Q] is nonzero: o_overflow=1 and the magnitude saturates to all ones (N-1 bits).
  - If the final magnitude is 0: the sign is forced to 0 (no negative zero emitted).
  - o_result = {sign, magnitude}; o_complete=1.
- DONE: lasts exactly one cycle, then IDLE.
  - o_complete returns to 0.
  - o_result and o_overflow hold.
- Latency: if start is accepted at edge t0, o_complete is high in the cycle following edge t0+N-1, i.e. N-1 edges after acceptance (31 for N=32).
- Throughput: one result per N+1 cycles.
- i_start while BUSY or DONE: ignored, not queued.
- Operand inputs may change freely after acceptance without affecting the result.
- i_start held high continuously: a new multiply starts on the first IDLE edge.

Decomposition:
- Shared package qformat_pkg:
  - N and Q defaults.
  - State enum {IDLE, BUSY, DONE}.
  - Constant SAT_MAG (all ones, N-1 bits).
  - Helper functions sm_sign and sm_mag.
  - The sign-magnitude adder uses the same package.
- No sub-module needed. The control FSM and the shift-add datapath sit in one module, roughly 150-250 lines.

Test Plan (N=32, Q=15):
- 1.5 × 2.0: A=0x0000C000, B=0x00010000 -> o_result=0x00018000, o_overflow=0. o_complete pulses exactly 31 edges after the start edge, for one cycle.
- -1.0 × 2.5: A=0x80008000, B=0x00014000 -> o_result=0x80014000. Then -1.0 × -1.0 (0x80008000 × 0x80008000) -> 0x00008000.
- Negative zero: A=0x80000000, B=0x00018000 -> o_result=0x00000000. Truncation: 0x00000001 × 0x00000001 -> 0x00000000, o_overflow=0.
- Overflow: A=0x40000000 (32768.0) × B=0x00020000 (4.0) -> 0x7FFFFFFF, o_overflow=1.
  - Same with B=0x80020000 -> 0xFFFFFFFF, o_overflow=1.
  - A following in-range multiply clears o_overflow.
- Handshake: pulse i_start with new operands at cycles 5 and 20 of a BUSY period.
  - Both are ignored and o_ready=0 throughout.
  - The result matches the first operands.
  - A start issued in the IDLE cycle after DONE is accepted.
- Reset mid-operation: assert rst at iteration 10. The next cycle shows IDLE, o_result=0, o_ready=1. A new multiply then completes correctly with full latency.
